// File: rtl/goc_tx_engine.sv
// Optical GOC transmitter: byte FIFO feeding a three-phase pulse-width modulator.
// Optional 10101010 preamble is built in when GOC_TX_PREAMBLE_EN is defined.
module goc_tx_engine #(
    parameter int FIFO_DEPTH = 16,
    parameter int SPEED_W    = 22,
    parameter int LAST_W     = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [SPEED_W-1:0]            goc_speed,
    input  logic                          goc_polarity,
    input  logic [LAST_W-1:0]             tx_data,
    input  logic                          tx_push,
    input  logic                          tx_last,
    output logic                          tx_full,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          nak,
    output logic                          goc_pad
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int BW    = $clog2(LAST_W);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef GOC_TX_PREAMBLE_EN
        S_PRE,
`endif
        S_LOAD,
        S_SYM,
        S_FIN
    } state_t;

    state_t state_reg, state_next;

    logic [LAST_W:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]    level_reg;
    logic                fifo_empty, push_ok, push_drop, pop;

    logic [SPEED_W-1:0]  spd_reg, phase_cnt_reg;
    logic [1:0]          phase_reg;
    logic [BW-1:0]       bit_idx_reg;
    logic [LAST_W-1:0]   sh_reg;
    logic                last_reg, undf_reg, ovf_reg, mod_reg;
    logic                bit_end, start_acc, gen_bit, gen_active;
`ifdef GOC_TX_PREAMBLE_EN
    logic [2:0]          pre_cnt_reg;
`endif

    assign fifo_empty = (level_reg == '0);
    assign tx_full    = (level_reg == LVL_W'(FIFO_DEPTH));
    assign tx_level   = level_reg;
    assign push_ok    = tx_push && !tx_full;
    assign push_drop  = tx_push && tx_full;
    assign start_acc  = (state_reg == S_IDLE) && start;
    assign bit_end    = (phase_reg == 2'd2) && (phase_cnt_reg == spd_reg);
    assign goc_pad    = mod_reg ^ goc_polarity;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= {tx_last, tx_data};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start)
`ifdef GOC_TX_PREAMBLE_EN
                    state_next = S_PRE;
`else
                    state_next = S_LOAD;
`endif
            end
`ifdef GOC_TX_PREAMBLE_EN
            S_PRE:  if (bit_end && pre_cnt_reg == 3'd7) state_next = S_LOAD;
`endif
            S_LOAD: state_next = fifo_empty ? S_FIN : S_SYM;
            S_SYM: begin
                if (bit_end && bit_idx_reg == BW'(LAST_W - 1))
                    state_next = last_reg ? S_FIN : S_LOAD;
            end
            S_FIN:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // LOAD emits the first clock of the next byte's leading high phase, so
    // consecutive bytes are seamless on the pad.
    always_comb begin
        busy    = (state_reg != S_IDLE);
        done    = (state_reg == S_FIN);
        nak     = done && (undf_reg || ovf_reg);
        pop     = (state_reg == S_LOAD) && !fifo_empty;
        gen_bit = 1'b0;
        case (state_reg)
`ifdef GOC_TX_PREAMBLE_EN
            S_PRE:  gen_bit = (phase_reg == 2'd0) || (phase_reg == 2'd1 && !pre_cnt_reg[0]);
`endif
            S_LOAD: gen_bit = !fifo_empty;
            S_SYM:  gen_bit = (phase_reg == 2'd0) || (phase_reg == 2'd1 && sh_reg[LAST_W-1]);
            default: gen_bit = 1'b0;
        endcase
        gen_active = pop || (state_reg == S_SYM);
`ifdef GOC_TX_PREAMBLE_EN
        gen_active = gen_active || (state_reg == S_PRE);
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            spd_reg       <= '0;
            phase_cnt_reg <= '0;
            phase_reg     <= 2'd0;
            bit_idx_reg   <= '0;
            sh_reg        <= '0;
            last_reg      <= 1'b0;
            undf_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            mod_reg       <= 1'b0;
`ifdef GOC_TX_PREAMBLE_EN
            pre_cnt_reg   <= 3'd0;
`endif
        end else begin
            mod_reg <= gen_bit;

            if (start_acc)
                ovf_reg <= push_drop;
            else if (push_drop)
                ovf_reg <= 1'b1;

            if (start_acc) begin
                spd_reg  <= goc_speed;
                undf_reg <= 1'b0;
            end else if (state_reg == S_LOAD && fifo_empty) begin
                undf_reg <= 1'b1;
            end

            if (state_reg == S_IDLE) begin
                phase_cnt_reg <= '0;
                phase_reg     <= 2'd0;
`ifdef GOC_TX_PREAMBLE_EN
                pre_cnt_reg   <= 3'd0;
`endif
            end else if (gen_active) begin
                if (phase_cnt_reg == spd_reg) begin
                    phase_cnt_reg <= '0;
                    phase_reg     <= (phase_reg == 2'd2) ? 2'd0 : phase_reg + 2'd1;
                end else begin
                    phase_cnt_reg <= phase_cnt_reg + 1'b1;
                end
            end

`ifdef GOC_TX_PREAMBLE_EN
            if (state_reg == S_PRE && bit_end)
                pre_cnt_reg <= pre_cnt_reg + 3'd1;
`endif

            if (pop) begin
                sh_reg      <= mem[rd_ptr_reg][LAST_W-1:0];
                last_reg    <= mem[rd_ptr_reg][LAST_W];
                bit_idx_reg <= '0;
            end else if (state_reg == S_SYM && bit_end) begin
                sh_reg      <= {sh_reg[LAST_W-2:0], 1'b0};
                bit_idx_reg <= bit_idx_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_goc_tx_engine.sv
// Randomized frame-level check of goc_tx_engine against a queue-based pad waveform model.
module tb_goc_tx_engine;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [21:0] goc_speed = '0;
    logic        goc_polarity = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_push = 1'b0;
    logic        tx_last = 1'b0;
    logic        tx_full;
    logic [2:0]  tx_level;
    logic        start = 1'b0;
    logic        busy, done, nak, goc_pad;

    int total = 0;
    int bad = 0;
    logic [8:0] mq[$];

    goc_tx_engine #(.FIFO_DEPTH(DEPTH), .SPEED_W(22), .LAST_W(8)) dut (
        .clk(clk), .resetn(resetn), .goc_speed(goc_speed), .goc_polarity(goc_polarity),
        .tx_data(tx_data), .tx_push(tx_push), .tx_last(tx_last), .tx_full(tx_full),
        .tx_level(tx_level), .start(start), .busy(busy), .done(done), .nak(nak),
        .goc_pad(goc_pad)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame: optional pushes, start (optionally with a simultaneous push),
    // then a cycle-by-cycle comparison against the expected pad waveform.
    task automatic run_frame(input int s, input bit pol, input int np, input int last_idx,
                             input int first_data, input bit push_with_start, input bit poke);
        bit   bq[$];
        bit   ovf, term;
        int   q0, pops, ph_len, byte_len, pre_len, wave_len, end_at, pk, lvl, idx, ph;
        logic [8:0] e;
        logic [7:0] pre;
        goc_polarity = pol;
        goc_speed    = 22'(s);
        for (int i = 0; i < np; i++) begin
            tx_push = 1'b1;
            tx_data = (i == 0 && first_data >= 0) ? 8'(first_data) : 8'($urandom);
            tx_last = (i == last_idx);
            e = {tx_last, tx_data};
            step();
            tx_push = 1'b0;
            if (mq.size() < DEPTH) mq.push_back(e);
            check_val("push_level", int'(tx_level), mq.size());
            check_val("push_full", int'(tx_full), int'(mq.size() == DEPTH));
        end

        start = 1'b1;
        ovf = 1'b0;
        if (push_with_start) begin
            tx_push = 1'b1;
            tx_data = 8'($urandom);
            tx_last = 1'($urandom);
            e = {tx_last, tx_data};
            if (mq.size() < DEPTH) mq.push_back(e);
            else ovf = 1'b1;
        end
        step();
        start   = 1'b0;
        tx_push = 1'b0;

        ph_len   = s + 1;
        byte_len = 24 * ph_len;
        pre_len  = 0;
`ifdef GOC_TX_PREAMBLE_EN
        pre = 8'hAA;
        for (int b = 7; b >= 0; b--) bq.push_back(pre[b]);
        pre_len = byte_len;
`else
        pre = 8'h00;
`endif
        q0 = mq.size();
        pops = 0;
        term = 1'b0;
        while (mq.size() > 0 && !term) begin
            e = mq.pop_front();
            pops++;
            for (int b = 7; b >= 0; b--) bq.push_back(e[b]);
            term = e[8];
        end
        wave_len = bq.size() * 3 * ph_len;
        end_at   = term ? wave_len + 1 : wave_len + 2;
        pk       = poke ? int'($urandom_range(1, end_at - 1)) : -1;

        for (int k = 1; k <= end_at + 1; k++) begin
            lvl = q0;
            for (int j = 0; j < pops; j++)
                if (1 + pre_len + j * byte_len < k) lvl--;
            if (k >= 2 && k <= wave_len + 1) begin
                idx = (k - 2) / ph_len;
                ph  = idx % 3;
                check_val("pad", int'(goc_pad),
                          int'(((ph == 0) || (ph == 1 && bq[idx / 3])) ^ pol));
            end else begin
                check_val("pad_quiet", int'(goc_pad), int'(pol));
            end
            check_val("busy", int'(busy), int'(k <= end_at));
            check_val("done", int'(done), int'(k == end_at));
            check_val("nak", int'(nak), int'(k == end_at && (!term || ovf)));
            check_val("level", int'(tx_level), lvl);
            if (k == pk) begin
                start     = 1'b1;
                goc_speed = 22'($urandom_range(0, 7));
            end else begin
                start = 1'b0;
            end
            if (k <= end_at) step();
        end
        start = 1'b0;
        $display("frame speed=%0d pol=%0d bytes=%0d term=%0d ovf=%0d left=%0d clocks=%0d",
                 s, pol, pops, term, ovf, mq.size(), end_at);
    endtask

    initial begin
        #3;
        check_val("rst_level", int'(tx_level), 0);
        check_val("rst_full", int'(tx_full), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_nak", int'(nak), 0);
        check_val("rst_pad", int'(goc_pad), 0);
        step();
        resetn = 1'b1;
        step();

        run_frame(1, 1'b0, 1, 0, 8'hA5, 1'b0, 1'b0);   // single 0xA5 frame
        run_frame(1, 1'b0, 3, 2, -1, 1'b0, 1'b0);      // three bytes back to back
        run_frame(1, 1'b1, 1, -1, -1, 1'b0, 1'b0);     // underflow after one byte
        run_frame(2, 1'b0, 5, -1, -1, 1'b0, 1'b0);     // overfill, then underflow
        run_frame(0, 1'b0, 0, -1, -1, 1'b0, 1'b0);     // empty FIFO
        run_frame(0, 1'b1, 4, 1, -1, 1'b1, 1'b1);      // drop on start cycle, leftovers
        run_frame(3, 1'b0, 0, -1, -1, 1'b1, 1'b1);     // drain leftovers

        for (int n = 0; n < 25; n++) begin
            int np_r;
            np_r = int'($urandom_range(0, 5));
            run_frame(int'($urandom_range(0, 3)), 1'($urandom), np_r,
                      int'($urandom_range(0, np_r)) - 1, -1, 1'($urandom), 1'($urandom));
        end

        // Reset in the middle of a byte aborts the frame silently.
        run_frame(1, 1'b1, 0, -1, -1, 1'b0, 1'b0);
        goc_polarity = 1'b1;
        goc_speed    = 22'd1;
        tx_push = 1'b1; tx_data = 8'h3C; tx_last = 1'b1;
        step();
        tx_push = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        check_val("pre_abort_busy", int'(busy), 1);
        resetn = 1'b0;
        #1;
        check_val("abort_pad", int'(goc_pad), 1);
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_level", int'(tx_level), 0);
        check_val("abort_full", int'(tx_full), 0);
        check_val("abort_done", int'(done), 0);
        step();
        resetn = 1'b1;
        mq.delete();
        for (int k = 0; k < 60; k++) begin
            step();
            check_val("post_abort_done", int'(done), 0);
            check_val("post_abort_pad", int'(goc_pad), 1);
        end
        $display("frame aborted by reset, queue discarded");
        run_frame(0, 1'b0, 0, -1, -1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/goc_tx_engine.md
GOC_TX_ENGINE -- requirements
Module: goc_tx_engine

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, number of queued data bytes (power of two, 2..256).
REQ-002 SHALL have parameter SPEED_W, default 22, width of the goc_speed phase-length field.
REQ-003 SHALL have parameter LAST_W, default 8, width of the transmit data byte (bits sent MSB-first).
REQ-004 clk  input  1  single clock; all logic is on the rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 goc_speed  input  SPEED_W  phase length minus one, in clocks.
REQ-007 goc_polarity  input  1  inverts goc_pad when high.
REQ-008 tx_data  input  LAST_W  byte to enqueue.
REQ-009 tx_push  input  1  enqueue tx_data when asserted for one clock.
REQ-010 tx_last  input  1  qualifies tx_push; marks the final byte of the frame.
REQ-011 tx_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-012 tx_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 start  input  1  one-clock request to begin a frame.
REQ-014 busy  output  1  high from accepted start until done.
REQ-015 done  output  1  one-clock pulse at frame end.
REQ-016 nak  output  1  valid with done; high means the frame failed.
REQ-017 goc_pad  output  1  modulated optical drive.

Function
REQ-018 FIFO entries SHALL be LAST_W+1 bits wide ({tx_last, tx_data}); a push while full SHALL be dropped and SHALL set the sticky per-frame flag ovf.
REQ-019 A simultaneous push and pop SHALL keep tx_level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 The state machine SHALL have the states IDLE, PRE, LOAD, SYM and FIN.
REQ-021 In IDLE, start SHALL latch goc_speed into spd_q, clear ovf and enter PRE (LOAD when the preamble is compiled out); start while busy SHALL be ignored.
REQ-022 LOAD SHALL pop one entry if FIFO not empty and enter SYM; if empty, SHALL enter FIN with nak=1 (underflow).
REQ-023 Each bit SHALL be 3 phases of spd_q+1 clocks: bit 1 = high,high,low; bit 0 = high,low,low.
REQ-024 SYM SHALL send LAST_W bits MSB-first, then go to FIN if the entry's last flag is set, else to LOAD; LOAD SHALL cost zero pad time (the next bit starts immediately after the last phase).
REQ-025 FIN SHALL pulse done for one clock, with nak = underflow OR ovf, then return to IDLE.
REQ-026 goc_pad SHALL equal the registered modulator bit XOR goc_polarity; the modulator bit SHALL be 0 outside PRE/SYM.
REQ-027 start with an empty FIFO SHALL give done=1 and nak=1 after the preamble (or 2 clocks later when the preamble is compiled out).
REQ-028 goc_speed changes during a frame SHALL NOT affect that frame.

Reset
REQ-029 resetn low SHALL asynchronously force the following: state=IDLE; FIFO empty; tx_level=0; tx_full=0; busy=0; done=0; nak=0; ovf=0; modulator bit=0, so goc_pad=goc_polarity.
REQ-030 A reset mid-frame SHALL abort the frame with no done pulse; queued data SHALL be discarded.

Configuration
REQ-031 Macro GOC_TX_PREAMBLE_EN defined: PRE SHALL transmit 8 bits 10101010 using the REQ-023 encoding before the first LOAD.
REQ-032 Macro GOC_TX_PREAMBLE_EN undefined: the PRE state and its counter SHALL be absent, and start SHALL go directly to LOAD.

Verification
REQ-033 goc_speed=1, polarity=0, no preamble, push 0xA5 with last, start -> 8 bits of 6 clocks each (48 clocks) with high-run lengths 4,2,4,2,2,4,2,4; then done=1, nak=0.
REQ-034 Push 3 bytes (last on the third), start -> 144 contiguous pad clocks (at goc_speed=1); tx_level decrements at each LOAD; done with nak=0.
REQ-035 Push 1 byte without last, start -> byte sent, then underflow -> done=1, nak=1.
REQ-036 FIFO_DEPTH=4: 5 pushes before start -> tx_full=1 after the 4th, 5th dropped; frame ends with nak=1.
REQ-037 polarity=1 while idle -> goc_pad=1; assert resetn low mid-SYM -> goc_pad=goc_polarity immediately, busy=0, no done.
REQ-038 With GOC_TX_PREAMBLE_EN defined, goc_speed=0 -> 24-clock preamble precedes data; empty-FIFO start -> done/nak after preamble.
